// File: rtl/magnitude_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : magnitude_sequencer
// Description : Time-multiplexed squared-magnitude engine for one FFT frame.
//               On start, captures BUFFER_SIZE complex bins and pushes one bin
//               per cycle through a two-stage pipeline that shares one
//               multiplier pair. Results stream out with valid/ready and are
//               also collected into a flat magnitude vector.
// Ports       : clk, reset_n (async, active low)
//               start, abort          - frame control
//               input_real/imag       - packed bins, bin k at [k*SAMPLE_SIZE +: SAMPLE_SIZE]
//               bin_valid/ready/index/mag - streamed result handshake
//               output_mags           - frame magnitudes, same packing as inputs
//               busy, done            - RUN state flag, one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module magnitude_sequencer #(
    parameter int SAMPLE_SIZE = 16,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] input_real,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] input_imag,
    output logic                               bin_valid,
    input  logic                               bin_ready,
    output logic [$clog2(BUFFER_SIZE)-1:0]     bin_index,
    output logic [SAMPLE_SIZE-1:0]             bin_mag,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] output_mags,
    output logic                               busy,
    output logic                               done
);

    localparam int              c_idx_w    = $clog2(BUFFER_SIZE);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BUFFER_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Captured frame
    logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] r_real;
    logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] r_imag;

    // Issue control
    logic [c_idx_w-1:0] r_issue_idx;
    logic               r_issue_pend;

    // Stage 1: squared components
    logic               r_s1_valid;
    logic [c_idx_w-1:0] r_s1_idx;
    logic [SAMPLE_SIZE-1:0] r_sq_re;
    logic [SAMPLE_SIZE-1:0] r_sq_im;

    // Stage 2: result registers
    logic                               r_bin_valid;
    logic [c_idx_w-1:0]                 r_bin_index;
    logic [SAMPLE_SIZE-1:0]             r_bin_mag;
    logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] r_output_mags;

    logic [SAMPLE_SIZE-1:0] w_re;
    logic [SAMPLE_SIZE-1:0] w_im;
    logic [SAMPLE_SIZE-1:0] w_sq_re;
    logic [SAMPLE_SIZE-1:0] w_sq_im;
    logic [SAMPLE_SIZE-1:0] w_mag;
    logic                   w_advance;
    logic                   w_accept_last;

    assign w_re = r_real[r_issue_idx*SAMPLE_SIZE +: SAMPLE_SIZE];
    assign w_im = r_imag[r_issue_idx*SAMPLE_SIZE +: SAMPLE_SIZE];

    // Only the low SAMPLE_SIZE bits of the full-width signed sum are kept, and
    // those bits of a two's-complement product/sum never depend on the upper
    // bits, so the arithmetic is evaluated directly at SAMPLE_SIZE width.
    assign w_sq_re = w_re * w_re;
    assign w_sq_im = w_im * w_im;
    assign w_mag   = r_sq_re + r_sq_im;

    // The whole pipe freezes while a result is offered but not taken.
    assign w_advance     = !(r_bin_valid && !bin_ready);
    assign w_accept_last = r_bin_valid && bin_ready && (r_bin_index == c_last_idx);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_accept_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture, issue and pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_real        <= '0;
            r_imag        <= '0;
            r_issue_idx   <= '0;
            r_issue_pend  <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_idx      <= '0;
            r_sq_re       <= '0;
            r_sq_im       <= '0;
            r_bin_valid   <= 1'b0;
            r_bin_index   <= '0;
            r_bin_mag     <= '0;
            r_output_mags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_real        <= input_real;
                        r_imag        <= input_imag;
                        r_output_mags <= '0;
                        r_issue_idx   <= '0;
                        r_issue_pend  <= 1'b1;
                        r_s1_valid    <= 1'b0;
                        r_bin_valid   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Slices already written stay in output_mags.
                        r_issue_pend <= 1'b0;
                        r_s1_valid   <= 1'b0;
                        r_bin_valid  <= 1'b0;
                    end else if (w_advance) begin
                        // Stage 1
                        r_s1_valid <= r_issue_pend;
                        if (r_issue_pend) begin
                            r_sq_re  <= w_sq_re;
                            r_sq_im  <= w_sq_im;
                            r_s1_idx <= r_issue_idx;
                            if (r_issue_idx == c_last_idx) begin
                                r_issue_pend <= 1'b0;
                            end else begin
                                r_issue_idx <= r_issue_idx + 1'b1;
                            end
                        end
                        // Stage 2; stage 1 is already empty when the last
                        // bin is accepted, so bin_valid drops on that edge.
                        r_bin_valid <= r_s1_valid;
                        if (r_s1_valid) begin
                            r_bin_mag   <= w_mag;
                            r_bin_index <= r_s1_idx;
                            r_output_mags[r_s1_idx*SAMPLE_SIZE +: SAMPLE_SIZE] <= w_mag;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bin_valid   = r_bin_valid;
    assign bin_index   = r_bin_index;
    assign bin_mag     = r_bin_mag;
    assign output_mags = r_output_mags;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_magnitude_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_magnitude_sequencer
// Description : Directed self-checking bench for magnitude_sequencer
//               (SAMPLE_SIZE=16, BUFFER_SIZE=8). Inputs change and outputs
//               are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_magnitude_sequencer;

    localparam int S = 16;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             bin_ready = 1'b0;
    logic [N*S-1:0]   input_real = '0;
    logic [N*S-1:0]   input_imag = '0;
    logic             bin_valid;
    logic [2:0]       bin_index;
    logic [S-1:0]     bin_mag;
    logic [N*S-1:0]   output_mags;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    magnitude_sequencer #(
        .SAMPLE_SIZE (S),
        .BUFFER_SIZE (N)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .input_real  (input_real),
        .input_imag  (input_imag),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_index   (bin_index),
        .bin_mag     (bin_mag),
        .output_mags (output_mags),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_bin(input int k, input logic [S-1:0] re, input logic [S-1:0] im);
        input_real[k*S +: S] = re;
        input_imag[k*S +: S] = im;
    endtask

    // Leaves the caller at the falling edge following the start edge (E0).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (bin_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bin_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (bin_mag !== 16'd0 || bin_index !== 3'd0) begin bad++; $display("FAIL reset_bin got=%0d/%0d want=0/0", bin_mag, bin_index); end
        total++; if (output_mags !== '0) begin bad++; $display("FAIL reset_mags got=%h want=0", output_mags); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic();
        logic [N*S-1:0] exp_vec;
        for (int k = 0; k < N; k++) begin
            set_bin(k, 16'd3, 16'd4);
            exp_vec[k*S +: S] = 16'd25;
        end
        bin_ready = 1'b1;
        pulse_start();
        total++; if (busy !== 1'b1 || bin_valid !== 1'b0) begin bad++; $display("FAIL basic_e0 got busy=%0b valid=%0b want 1/0", busy, bin_valid); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if (bin_valid !== 1'b0) begin bad++; $display("FAIL basic_e1_valid got=%0b want=0", bin_valid); end
            end else if (c <= 9) begin
                total++;
                if (bin_valid !== 1'b1 || bin_index !== 3'(c - 2) || bin_mag !== 16'd25 || done !== 1'b0) begin
                    bad++; $display("FAIL basic_bin c=%0d got v=%0b i=%0d m=%0d d=%0b want 1/%0d/25/0", c, bin_valid, bin_index, bin_mag, done, c - 2);
                end
            end else begin
                total++; if (done !== 1'b1 || busy !== 1'b0 || bin_valid !== 1'b0) begin bad++; $display("FAIL basic_done got d=%0b b=%0b v=%0b want 1/0/0", done, busy, bin_valid); end
                total++; if (output_mags !== exp_vec) begin bad++; $display("FAIL basic_mags got=%h want=%h", output_mags, exp_vec); end
            end
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
    endtask

    task automatic test_wrap();
        logic [S-1:0]   wexp [N];
        logic [N*S-1:0] exp_vec;
        for (int k = 0; k < N; k++) set_bin(k, 16'd0, 16'd0);
        set_bin(0, 16'hFFFD, 16'd0);
        set_bin(1, 16'd0, 16'h8000);
        set_bin(2, 16'h0100, 16'd0);
        set_bin(3, 16'd181, 16'd181);
        wexp = '{16'd9, 16'd0, 16'd0, 16'hFFF2, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int k = 0; k < N; k++) exp_vec[k*S +: S] = wexp[k];
        bin_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                total++;
                if (bin_valid !== 1'b1 || bin_index !== 3'(c - 2) || bin_mag !== wexp[c-2]) begin
                    bad++; $display("FAIL wrap_bin k=%0d got v=%0b i=%0d m=%h want 1/%0d/%h", c - 2, bin_valid, bin_index, bin_mag, c - 2, wexp[c-2]);
                end
            end else if (c == 10) begin
                total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%0b want=1", done); end
                total++; if (output_mags !== exp_vec) begin bad++; $display("FAIL wrap_mags got=%h want=%h", output_mags, exp_vec); end
            end
        end
    endtask

    task automatic test_backpressure();
        int           got = 0;
        int           dones = 0;
        logic         pv = 1'b0;
        logic         pr = 1'b0;
        logic [S-1:0] pm = '0;
        logic [2:0]   pi = '0;
        for (int k = 0; k < N; k++) set_bin(k, S'(k), S'(k + 1));
        bin_ready = 1'b0;
        pulse_start();
        for (int c = 0; c < 300 && dones == 0; c++) begin
            if (pv && !pr) begin
                total++;
                if (bin_valid !== 1'b1 || bin_mag !== pm || bin_index !== pi) begin
                    bad++; $display("FAIL bp_stall got v=%0b i=%0d m=%0d want 1/%0d/%0d", bin_valid, bin_index, bin_mag, pi, pm);
                end
            end
            if (done === 1'b1) begin
                dones++;
                total++; if (got != N) begin bad++; $display("FAIL bp_done_early got=%0d bins want=%0d", got, N); end
            end
            bin_ready = 1'($urandom_range(0, 1));
            if (bin_valid === 1'b1 && bin_ready) begin
                total++;
                if (bin_index !== 3'(got) || bin_mag !== S'(got * got + (got + 1) * (got + 1))) begin
                    bad++; $display("FAIL bp_bin got i=%0d m=%0d want %0d/%0d", bin_index, bin_mag, got, got * got + (got + 1) * (got + 1));
                end
                got++;
            end
            pv = bin_valid; pr = bin_ready; pm = bin_mag; pi = bin_index;
            @(negedge clk);
        end
        total++; if (got != N || dones != 1) begin bad++; $display("FAIL bp_count got bins=%0d dones=%0d want %0d/1", got, dones, N); end
        for (int c = 0; c < 3; c++) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL bp_extra_done got=%0b want=0", done); end
            @(negedge clk);
        end
        bin_ready = 1'b1;
    endtask

    task automatic test_ignored_start();
        int got = 0;
        int dones = 0;
        for (int k = 0; k < N; k++) set_bin(k, 16'd1, 16'd2);
        bin_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 3) begin
                for (int k = 0; k < N; k++) set_bin(k, 16'd7, 16'd0);
            end
            if (bin_valid === 1'b1) begin
                total++;
                if (bin_index !== 3'(got) || bin_mag !== 16'd5) begin
                    bad++; $display("FAIL ign_bin got i=%0d m=%0d want %0d/5", bin_index, bin_mag, got);
                end
                got++;
            end
            if (done === 1'b1) dones++;
            // start mid-frame and start coinciding with done must both be ignored
            start = (c == 3) || (done === 1'b1);
        end
        start = 1'b0;
        total++; if (got != N || dones != 1) begin bad++; $display("FAIL ign_count got bins=%0d dones=%0d want %0d/1", got, dones, N); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_restart got busy=%0b want=0", busy); end
    endtask

    task automatic test_abort();
        logic [N*S-1:0] exp_vec = '0;
        for (int k = 0; k < N; k++) set_bin(k, S'(k), 16'd0);
        for (int k = 0; k < 4; k++) exp_vec[k*S +: S] = S'(k * k);
        bin_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 5; c++) @(negedge clk);
        total++; if (bin_valid !== 1'b1 || bin_index !== 3'd3 || bin_mag !== 16'd9) begin bad++; $display("FAIL abort_bin3 got v=%0b i=%0d m=%0d want 1/3/9", bin_valid, bin_index, bin_mag); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (busy !== 1'b0 || bin_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_state got b=%0b v=%0b d=%0b want 0/0/0", busy, bin_valid, done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got d=%0b b=%0b want 0/0", done, busy); end
        end
        total++; if (output_mags !== exp_vec) begin bad++; $display("FAIL abort_mags got=%h want=%h", output_mags, exp_vec); end
        for (int k = 0; k < N; k++) set_bin(k, S'(k), 16'd1);
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                total++;
                if (bin_valid !== 1'b1 || bin_index !== 3'(c - 2) || bin_mag !== S'((c - 2) * (c - 2) + 1)) begin
                    bad++; $display("FAIL abort_rerun k=%0d got v=%0b i=%0d m=%0d want 1/%0d/%0d", c - 2, bin_valid, bin_index, bin_mag, c - 2, (c - 2) * (c - 2) + 1);
                end
            end else if (c == 10) begin
                total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_rerun_done got=%0b want=1", done); end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < N; k++) set_bin(k, 16'd2, 16'd0);
        bin_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 3; c++) @(negedge clk);
        total++; if (bin_valid !== 1'b1 || bin_mag !== 16'd4) begin bad++; $display("FAIL arst_pre got v=%0b m=%0d want 1/4", bin_valid, bin_mag); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bin_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_ctrl got b=%0b v=%0b d=%0b want 0/0/0", busy, bin_valid, done); end
        total++; if (bin_mag !== 16'd0 || bin_index !== 3'd0 || output_mags !== '0) begin bad++; $display("FAIL arst_data got m=%0d i=%0d mags=%h want 0", bin_mag, bin_index, output_mags); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || bin_valid !== 1'b0) begin bad++; $display("FAIL arst_idle got b=%0b v=%0b want 0/0", busy, bin_valid); end
        end
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        total++; if (bin_valid !== 1'b1 || bin_index !== 3'd0 || bin_mag !== 16'd4) begin bad++; $display("FAIL arst_rerun got v=%0b i=%0d m=%0d want 1/0/4", bin_valid, bin_index, bin_mag); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
